approx_accum_adder: RTL and testbench
=====================================

// Module: approx_accum_adder
// PURPOSE
// - Streaming accumulator for the ASPEN datapath, built on a parametrised lower-part-approximate adder.
// - Sums a burst of WIDTH-bit operands (in_last terminates) and returns one result per burst.
// - Add mode is selectable at runtime per burst: exact, or approximate (low APPROX_LSB bits bypassed).
// - Used for neuron membrane/partial-sum accumulation where approximation trades error for power.
// PARAMETERS
// - WIDTH      16   operand/accumulator width, >= 2
// - APPROX_LSB 3    approximate low bits K, 0 <= K < WIDTH; K=0 makes approx mode identical to exact
// - MAX_BEATS  256  max beats per burst; reaching it without in_last force-terminates the burst
// PORTS
// - clk        in   1                   rising-edge clock
// - rst        in   1                   asynchronous, active-high reset
// - in_valid   in   1                   operand valid
// - in_ready   out  1                   operand accepted when in_valid & in_ready
// - in_data    in   WIDTH               operand (B input of adder)
// - in_last    in   1                   final beat of burst
// - approx_en  in   1                   1=approximate add, 0=exact; sampled on first beat of burst
// - out_valid  out  1                   result valid; held until out_ready
// - out_ready  in   1                   result consumer ready
// - out_sum    out  WIDTH               burst sum, modulo 2^WIDTH
// - out_ovf    out  1                   sticky: carry out of MSB on any beat of the burst
// - out_count  out  $clog2(MAX_BEATS+1) beats accumulated in the burst
// - out_trunc  out  1                   burst ended by MAX_BEATS, not by in_last
// BEHAVIOUR
// - Clock/reset: one clock, clk; reset rst is asynchronous, active-high.
// - Reset: all outputs 0, in_ready=0 during rst, state IDLE, acc=0, mode=exact.
// - Adder f(a,b), a=acc, b=in_data, K=APPROX_LSB.
//   - exact:  {c,s} = a + b
//   - approx: s[K-1:0] = b[K-1:0]; {c,s[W-1:K]} = a[W-1:K] + b[W-1:K] + a[K-1]; carry-in 0 when K=0
//   - c is the carry out; ovf_r |= c
// - FSM: IDLE, ACC, HOLD; in_ready = (state != HOLD) & ~rst.
//   - IDLE, beat accepted:
//     - mode <= approx_en; acc <= f(0, in_data), which is exact in either mode
//     - cnt <= 1; ovf_r <= 0
//     - next state ACC, or HOLD if in_last or MAX_BEATS==1
//   - ACC, beat accepted:
//     - acc <= f(acc, in_data) in the latched mode; cnt++; approx_en ignored
//     - in_last -> HOLD
//     - cnt reaching MAX_BEATS without in_last -> HOLD with trunc=1
//   - HOLD:
//     - out_valid=1; out_sum/out_ovf/out_count/out_trunc stable and equal to the final registers
//     - on out_valid & out_ready: go IDLE, clear acc/cnt/ovf/trunc
//     - in_ready rises the next cycle
// - Latency: final beat accepted at cycle t -> out_valid high at t+1; no bubbles within a burst.
// - Backpressure: the accumulator never advances without handshake; in_valid low cycles are idle.
// - Overflow: sum wraps modulo 2^WIDTH, never saturates; out_ovf reports it.
// - out_* are don't-care-free: 0 whenever out_valid=0.
// - rst mid-burst or in HOLD: burst discarded, all state cleared asynchronously; no output pulse.
// TESTING
// - Exact, W=16: beats 0x0005, 0x0003(last) -> out_sum=0x0008, ovf=0, count=2, 1 cycle after last.
// - Approx, K=3: same beats -> out_sum=0x000B (low3=011, upper=0+0+a[2]=1), ovf=0.
// - Approx wrap: beats 0xFFF8, 0x0010(last) -> out_sum=0x0008, ovf=1; exact gives 0x0008, ovf=1.
// - Backpressure: out_ready=0 for 5 cycles -> in_ready=0, outputs stable; then 1 handshake, in_ready=1 next cycle.
// - MAX_BEATS=4: five beats of 1, no last -> result 4, trunc=1; 5th beat waits for next burst.
// - rst asserted mid-burst after 2 beats -> out_valid stays 0; new burst 0x0001(last) -> out_sum=0x0001.

Source files
------------

// File: rtl/approx_accum_adder.sv
// approx_accum_adder: streaming burst accumulator built on a lower-part
// approximate adder. Each burst of WIDTH-bit operands (terminated by in_last,
// or forcibly after MAX_BEATS beats) is summed into one result. The add mode
// (exact or approximate) is latched on the first beat of each burst.
//
// Approximate add, with K = APPROX_LSB:
//   - the low K result bits are copied from the operand,
//   - the upper bits are added exactly,
//   - acc[K-1] is used as the carry-in to the upper part.
// The first beat adds to zero, so it is exact in either mode.

module approx_accum_adder #(
  parameter int WIDTH      = 16,
  parameter int APPROX_LSB = 3,
  parameter int MAX_BEATS  = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_last,
  input  logic                             approx_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_sum,
  output logic                             out_ovf,
  output logic [$clog2(MAX_BEATS+1)-1:0]   out_count,
  output logic                             out_trunc
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic            ovf_reg;
  logic            trunc_reg;
  logic            mode_reg;

  logic            beat;
  logic [WIDTH:0]  exact_full;
  logic [WIDTH:0]  approx_full;
  logic [WIDTH:0]  sel_full;
  logic [CW-1:0]   cnt_inc;
  logic            acc_done;
  logic            first_done;

  // Operands are only taken while no result is being held, and never in reset.
  assign in_ready = (state_reg != HOLD) & ~rst;
  assign beat     = in_valid & in_ready;

  // Exact adder: full carry chain, carry out in the top bit.
  assign exact_full = {1'b0, acc_reg} + {1'b0, in_data};

  // Approximate adder: the low part is bypassed. With K=0 it is the exact adder.
  generate
    if (APPROX_LSB == 0) begin : g_no_approx
      assign approx_full = exact_full;
    end else begin : g_approx
      logic [WIDTH-APPROX_LSB:0] hi_sum;
      assign hi_sum = {1'b0, acc_reg[WIDTH-1:APPROX_LSB]}
                    + {1'b0, in_data[WIDTH-1:APPROX_LSB]}
                    + {{(WIDTH-APPROX_LSB){1'b0}}, acc_reg[APPROX_LSB-1]};
      assign approx_full = {hi_sum, in_data[APPROX_LSB-1:0]};
    end
  endgenerate

  // Pick the adder output for the mode latched at the start of the burst.
  assign sel_full = mode_reg ? approx_full : exact_full;

  // Beat counter increment and burst-termination conditions.
  assign cnt_inc    = cnt_reg + CW'(1);
  assign acc_done   = in_last | (cnt_inc == MAX_CNT);
  assign first_done = in_last | (MAX_BEATS == 1);

  // Burst FSM. The accumulator registers drive the outputs directly.
  // Their values are presented only while HOLD, and are cleared when the
  // result is handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      trunc_reg <= 1'b0;
      mode_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (beat) begin
            mode_reg  <= approx_en;
            acc_reg   <= in_data;
            cnt_reg   <= CW'(1);
            ovf_reg   <= 1'b0;
            trunc_reg <= first_done & ~in_last;
            state_reg <= first_done ? HOLD : ACC;
          end
        end
        ACC: begin
          if (beat) begin
            acc_reg   <= sel_full[WIDTH-1:0];
            ovf_reg   <= ovf_reg | sel_full[WIDTH];
            cnt_reg   <= cnt_inc;
            trunc_reg <= acc_done & ~in_last;
            if (acc_done) begin
              state_reg <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            trunc_reg <= 1'b0;
            mode_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Result outputs: the accumulator registers are shown only in HOLD.
  // Otherwise every output is zero.
  assign out_valid = (state_reg == HOLD);
  assign out_sum   = out_valid ? acc_reg : '0;
  assign out_ovf   = out_valid & ovf_reg;
  assign out_count = out_valid ? cnt_reg : '0;
  assign out_trunc = out_valid & trunc_reg;

endmodule

// File: tb/tb_approx_accum_adder.sv
// Directed bench for approx_accum_adder (WIDTH=16, APPROX_LSB=3, MAX_BEATS=4).
// Expected values are hand-computed constants.

module tb_approx_accum_adder;

  localparam int W  = 16;
  localparam int K  = 3;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          approx_en;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_ovf;
  logic [CW-1:0] out_count;
  logic          out_trunc;

  int errors = 0;
  int checks = 0;

  approx_accum_adder #(
    .WIDTH(W),
    .APPROX_LSB(K),
    .MAX_BEATS(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_ovf(out_ovf),
    .out_count(out_count),
    .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for in_ready, then complete the handshake.
  task automatic send(input logic [W-1:0] d, input logic last, input logic ap);
    int n;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    approx_en = ap;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    approx_en = 1'b0;
  endtask

  // Called one cycle after the final beat: check the held result,
  // then hand it off and confirm the return to idle.
  task automatic collect(input string tag, input logic [W-1:0] s, input logic o,
                         input logic [CW-1:0] c, input logic t);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_sum"},   {16'd0, out_sum}, {16'd0, s});
    check({tag, "_ovf"},   {31'd0, out_ovf}, {31'd0, o});
    check({tag, "_count"}, {{(32-CW){1'b0}}, out_count}, {{(32-CW){1'b0}}, c});
    check({tag, "_trunc"}, {31'd0, out_trunc}, {31'd0, t});
    $display("burst %s: sum=0x%04h ovf=%0d count=%0d trunc=%0d", tag, out_sum, out_ovf,
             out_count, out_trunc);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_done_sum"},   {16'd0, out_sum}, 32'd0);
    check({tag, "_done_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    approx_en = 1'b0;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_valid",    {31'd0, out_valid}, 32'd0);
    check("rst_sum",      {16'd0, out_sum}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Exact: 5 + 3 = 8, result one cycle after last
    send(16'h0005, 1'b0, 1'b0);
    send(16'h0003, 1'b1, 1'b0);
    collect("exact", 16'h0008, 1'b0, 3'd2, 1'b0);

    // Approx: low3 = 011, upper = 0+0+a[2]=1 -> 0x000B; approx_en ignored on beat 2
    send(16'h0005, 1'b0, 1'b1);
    send(16'h0003, 1'b1, 1'b0);
    collect("approx", 16'h000B, 1'b0, 3'd2, 1'b0);

    // Approx wrap: 0xFFF8 + 0x0010 -> 0x0008 with carry
    send(16'hFFF8, 1'b0, 1'b1);
    send(16'h0010, 1'b1, 1'b1);
    collect("approx_wrap", 16'h0008, 1'b1, 3'd2, 1'b0);

    // Exact wrap: same beats
    send(16'hFFF8, 1'b0, 1'b0);
    send(16'h0010, 1'b1, 1'b0);
    collect("exact_wrap", 16'h0008, 1'b1, 3'd2, 1'b0);

    // Sticky overflow: 0xFFFF + 2 carries, + 1 does not; sum 2, ovf stays 1
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'h0002, 1'b0, 1'b0);
    send(16'h0001, 1'b1, 1'b0);
    collect("sticky_ovf", 16'h0002, 1'b1, 3'd3, 1'b0);

    // Idle in_valid gaps inside a burst do not advance the accumulator
    send(16'h0001, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    send(16'h0002, 1'b1, 1'b0);
    collect("gaps", 16'h0003, 1'b0, 3'd2, 1'b0);

    // Backpressure: out_ready low for 5 cycles with a pending operand offered
    send(16'h0007, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h0100;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
      check("bp_sum",      {16'd0, out_sum}, 32'h0007);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect("backpressure", 16'h0007, 1'b0, 3'd1, 1'b0);

    // MAX_BEATS=4: four beats of 1 without last force-terminate;
    // the 5th beat waits for the next burst
    for (int i = 0; i < 4; i++) begin
      send(16'h0001, 1'b0, 1'b0);
    end
    in_valid = 1'b1;
    in_data  = 16'h0001;
    in_last  = 1'b1;
    check("trunc_5th_blocked", {31'd0, in_ready}, 32'd0);
    collect("trunc", 16'h0004, 1'b0, 3'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect("fifth_beat", 16'h0001, 1'b0, 3'd1, 1'b0);

    // Reset mid-burst after two beats: no output, then a clean new burst
    send(16'h0009, 1'b0, 1'b0);
    send(16'h0009, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    check("midrst_valid0", {31'd0, out_valid}, 32'd0);
    tick();
    check("midrst_valid1", {31'd0, out_valid}, 32'd0);
    send(16'h0001, 1'b1, 1'b0);
    collect("after_midrst", 16'h0001, 1'b0, 3'd1, 1'b0);

    // Reset while holding a result clears the outputs asynchronously
    send(16'h0005, 1'b1, 1'b0);
    check("hold_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("holdrst_valid", {31'd0, out_valid}, 32'd0);
    check("holdrst_sum",   {16'd0, out_sum}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("holdrst_ready", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
